// File: rtl/data_mem_controller_if.sv
// data_mem_controller_if: core-side and memory-side buses of the data-memory arbiter
interface data_mem_controller_if #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int READ_NUM  = 4
);
  logic [NUM_CORES-1:0]                    core_read_valid;
  logic [NUM_CORES*ADDR_BITS-1:0]          core_read_address;
  logic [NUM_CORES-1:0]                    core_read_ready;
  logic [NUM_CORES*READ_NUM*DATA_BITS-1:0] core_read_data;
  logic [NUM_CORES-1:0]                    core_write_valid;
  logic [NUM_CORES*ADDR_BITS-1:0]          core_write_address;
  logic [NUM_CORES*DATA_BITS-1:0]          core_write_data;
  logic [NUM_CORES-1:0]                    core_write_ready;
  logic                                    mem_read_valid;
  logic [ADDR_BITS-1:0]                    mem_read_address;
  logic                                    mem_read_ready;
  logic [READ_NUM*DATA_BITS-1:0]           mem_read_data;
  logic                                    mem_write_valid;
  logic [ADDR_BITS-1:0]                    mem_write_address;
  logic [DATA_BITS-1:0]                    mem_write_data;
  logic                                    mem_write_ready;
  modport slave (
    input  core_read_valid, core_read_address, core_write_valid, core_write_address,
           core_write_data, mem_read_ready, mem_read_data, mem_write_ready,
    output core_read_ready, core_read_data, core_write_ready, mem_read_valid,
           mem_read_address, mem_write_valid, mem_write_address, mem_write_data
  );
  modport master (
    output core_read_valid, core_read_address, core_write_valid, core_write_address,
           core_write_data, mem_read_ready, mem_read_data, mem_write_ready,
    input  core_read_ready, core_read_data, core_write_ready, mem_read_valid,
           mem_read_address, mem_write_valid, mem_write_address, mem_write_data
  );
endinterface

// File: rtl/data_mem_controller.sv
// data_mem_controller: round-robin arbiter of per-core read/write ports onto one data-memory channel
module data_mem_controller #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int READ_NUM  = 4
) (
  input logic                  clk,
  input logic                  reset,
  data_mem_controller_if.slave bus
);
  localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int LW = READ_NUM * DATA_BITS;
  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;
  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d, rr_ptr_q, rr_ptr_d, idx;
  logic                 mem_read_valid_q, mem_read_valid_d, mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0] mem_read_address_q, mem_read_address_d, mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0] mem_write_data_q, mem_write_data_d;
  logic [NUM_CORES-1:0] core_read_ready_q, core_read_ready_d, core_write_ready_q, core_write_ready_d;
  logic [LW-1:0]        core_read_data_q [NUM_CORES];
  logic [LW-1:0]        core_read_data_d [NUM_CORES];
  logic [ADDR_BITS-1:0] rd_addr [NUM_CORES];
  logic [ADDR_BITS-1:0] wr_addr [NUM_CORES];
  logic [DATA_BITS-1:0] wr_data [NUM_CORES];
  logic                 found;
  logic                 relay_valid;
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slice
    assign rd_addr[g] = bus.core_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_addr[g] = bus.core_write_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_data[g] = bus.core_write_data[g*DATA_BITS +: DATA_BITS];
    assign bus.core_read_data[g*LW +: LW] = core_read_data_q[g];
  end
  assign bus.mem_read_valid    = mem_read_valid_q;
  assign bus.mem_read_address  = mem_read_address_q;
  assign bus.mem_write_valid   = mem_write_valid_q;
  assign bus.mem_write_address = mem_write_address_q;
  assign bus.mem_write_data    = mem_write_data_q;
  assign bus.core_read_ready   = core_read_ready_q;
  assign bus.core_write_ready  = core_write_ready_q;
  // the granted core's valid that matches the transaction being relayed
  assign relay_valid = (|core_read_ready_q) ? bus.core_read_valid[grant_q] : bus.core_write_valid[grant_q];
  // arbitration, memory handshake and ready relay
  always_comb begin
    state_d             = state_q;
    grant_d             = grant_q;
    rr_ptr_d            = rr_ptr_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    core_read_ready_d   = core_read_ready_q;
    core_write_ready_d  = core_write_ready_q;
    core_read_data_d    = core_read_data_q;
    found               = 1'b0;
    idx                 = '0;
    case (state_q)
      IDLE:
        for (int i = 0; i < NUM_CORES; i++) begin
          idx = GW'((int'(rr_ptr_q) + i) % NUM_CORES);
          if (!found && (bus.core_read_valid[idx] || bus.core_write_valid[idx])) begin
            found   = 1'b1;
            grant_d = idx;
            if (bus.core_read_valid[idx]) begin
              mem_read_valid_d   = 1'b1;
              mem_read_address_d = rd_addr[idx];
              state_d            = READ_WAIT;
            end else begin
              mem_write_valid_d   = 1'b1;
              mem_write_address_d = wr_addr[idx];
              mem_write_data_d    = wr_data[idx];
              state_d             = WRITE_WAIT;
            end
          end
        end
      READ_WAIT:
        if (bus.mem_read_ready) begin
          mem_read_valid_d          = 1'b0;
          core_read_data_d[grant_q] = bus.mem_read_data;
          core_read_ready_d[grant_q] = 1'b1;
          state_d                   = RELAY;
        end
      WRITE_WAIT:
        if (bus.mem_write_ready) begin
          mem_write_valid_d           = 1'b0;
          core_write_ready_d[grant_q] = 1'b1;
          state_d                     = RELAY;
        end
      RELAY:
        if (!relay_valid) begin
          core_read_ready_d  = '0;
          core_write_ready_d = '0;
          rr_ptr_d           = (int'(grant_q) == NUM_CORES - 1) ? '0 : grant_q + 1'b1;
          state_d            = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= IDLE;
      grant_q             <= '0;
      rr_ptr_q            <= '0;
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      core_read_ready_q   <= '0;
      core_write_ready_q  <= '0;
      core_read_data_q    <= '{default: '0};
    end else begin
      state_q             <= state_d;
      grant_q             <= grant_d;
      rr_ptr_q            <= rr_ptr_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      core_read_ready_q   <= core_read_ready_d;
      core_write_ready_q  <= core_write_ready_d;
      core_read_data_q    <= core_read_data_d;
    end
  end
endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller: scenario tasks plus randomized rounds against a round-robin service model
module tb_data_mem_controller;
  localparam int NC = 2;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int RN = 4;
  localparam int LW = RN * DB;
  typedef struct {int core; bit rd;} op_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  data_mem_controller_if #(.NUM_CORES(NC), .ADDR_BITS(AB), .DATA_BITS(DB), .READ_NUM(RN)) bus ();
  data_mem_controller #(.NUM_CORES(NC), .ADDR_BITS(AB), .DATA_BITS(DB), .READ_NUM(RN)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int total = 0;
  int bad = 0;
  int rd_lat = 0;
  int wr_lat = 0;
  int rc = 0;
  int wc = 0;
  int rr_model = 0;
  logic [DB-1:0] mem [256];
  logic [AB-1:0] seen_rd_addr, seen_wr_addr;
  logic [DB-1:0] seen_wr_data;
  logic [LW-1:0] exp_line [NC];

  function automatic logic [LW-1:0] line_of(input logic [AB-1:0] a);
    return {mem[AB'(a + 3)], mem[AB'(a + 2)], mem[AB'(a + 1)], mem[a]};
  endfunction

  function automatic logic [NC*LW-1:0] flat_lines();
    logic [NC*LW-1:0] f;
    for (int k = 0; k < NC; k++) f[k*LW +: LW] = exp_line[k];
    return f;
  endfunction

  // memory responder: answers each request after a programmable number of cycles
  initial begin
    bus.mem_read_ready = 1'b0;
    bus.mem_write_ready = 1'b0;
    bus.mem_read_data = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_read_valid && !bus.mem_read_ready) begin
        if (rc >= rd_lat) begin
          bus.mem_read_ready = 1'b1;
          bus.mem_read_data = line_of(bus.mem_read_address);
          seen_rd_addr = bus.mem_read_address;
          rc = 0;
        end else rc++;
      end else begin
        bus.mem_read_ready = 1'b0;
        rc = 0;
      end
      if (bus.mem_write_valid && !bus.mem_write_ready) begin
        if (wc >= wr_lat) begin
          bus.mem_write_ready = 1'b1;
          seen_wr_addr = bus.mem_write_address;
          seen_wr_data = bus.mem_write_data;
          wc = 0;
        end else wc++;
      end else begin
        bus.mem_write_ready = 1'b0;
        wc = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if ((bus.core_read_ready | bus.core_write_ready) != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    total++;
    if ({bus.mem_read_valid, bus.mem_write_valid, bus.core_read_ready, bus.core_write_ready} !== '0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0", {bus.mem_read_valid, bus.mem_write_valid, bus.core_read_ready, bus.core_write_ready});
    end
    total++;
    if ({bus.mem_read_address, bus.mem_write_address, bus.mem_write_data} !== '0) begin
      bad++;
      $display("FAIL reset_mem_bus got=%h want=0", {bus.mem_read_address, bus.mem_write_address, bus.mem_write_data});
    end
    total++;
    if (bus.core_read_data !== '0) begin
      bad++;
      $display("FAIL reset_read_data got=%h want=0", bus.core_read_data);
    end
    for (int k = 0; k < NC; k++) exp_line[k] = '0;
    rr_model = 0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    bit ok;
    rd_lat = 0;
    bus.core_read_address = {8'h10, 8'h00};
    bus.core_read_valid = 2'b10;
    wait_ready(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout got=no-ready want=ready"); end
    total++;
    if (seen_rd_addr !== 8'h10) begin bad++; $display("FAIL single_addr got=%h want=10", seen_rd_addr); end
    total++;
    if (bus.core_read_ready !== 2'b10 || bus.core_write_ready !== 2'b00) begin
      bad++;
      $display("FAIL single_ready got=%b/%b want=10/00", bus.core_read_ready, bus.core_write_ready);
    end
    total++;
    if (bus.core_read_data[LW +: LW] !== 32'h44332211) begin
      bad++;
      $display("FAIL single_slice1 got=%h want=44332211", bus.core_read_data[LW +: LW]);
    end
    total++;
    if (bus.core_read_data[0 +: LW] !== 32'h0) begin
      bad++;
      $display("FAIL single_slice0 got=%h want=0", bus.core_read_data[0 +: LW]);
    end
    exp_line[1] = 32'h44332211;
    bus.core_read_valid = 2'b00;
    rr_model = 0;
    tick();
    total++;
    if (bus.core_read_ready !== 2'b00) begin bad++; $display("FAIL single_release got=%b want=00", bus.core_read_ready); end
  endtask

  task automatic test_rr_round(input logic [NC-1:0] rv, input logic [NC-1:0] wv,
                               input logic [AB-1:0] ra [NC], input logic [AB-1:0] wa [NC],
                               input logic [DB-1:0] wd [NC]);
    op_t exp_q[$];
    logic [NC-1:0] pr, pw, oh;
    int p;
    bit ok;
    pr = rv;
    pw = wv;
    p = rr_model;
    while ((pr | pw) != '0) begin
      for (int i = 0; i < NC; i++) begin
        int k;
        k = (p + i) % NC;
        if (pr[k] || pw[k]) begin
          exp_q.push_back('{core: k, rd: pr[k]});
          if (pr[k]) pr[k] = 1'b0; else pw[k] = 1'b0;
          p = (k + 1) % NC;
          break;
        end
      end
    end
    for (int k = 0; k < NC; k++) begin
      bus.core_read_address[k*AB +: AB] = ra[k];
      bus.core_write_address[k*AB +: AB] = wa[k];
      bus.core_write_data[k*DB +: DB] = wd[k];
    end
    bus.core_read_valid = rv;
    bus.core_write_valid = wv;
    foreach (exp_q[n]) begin
      int c;
      c = exp_q[n].core;
      oh = NC'(1) << c;
      wait_ready(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rr_timeout core=%0d got=no-ready want=ready", c); end
      if (exp_q[n].rd) begin
        exp_line[c] = line_of(ra[c]);
        total++;
        if (bus.core_read_ready !== oh || bus.core_write_ready !== '0) begin
          bad++;
          $display("FAIL rr_read_ready got=%b/%b want=%b/00", bus.core_read_ready, bus.core_write_ready, oh);
        end
        total++;
        if (seen_rd_addr !== ra[c]) begin bad++; $display("FAIL rr_read_addr got=%h want=%h", seen_rd_addr, ra[c]); end
        total++;
        if (bus.core_read_data !== flat_lines()) begin
          bad++;
          $display("FAIL rr_read_data got=%h want=%h", bus.core_read_data, flat_lines());
        end
        bus.core_read_valid[c] = 1'b0;
      end else begin
        total++;
        if (bus.core_write_ready !== oh || bus.core_read_ready !== '0) begin
          bad++;
          $display("FAIL rr_write_ready got=%b/%b want=00/%b", bus.core_read_ready, bus.core_write_ready, oh);
        end
        total++;
        if (seen_wr_addr !== wa[c] || seen_wr_data !== wd[c]) begin
          bad++;
          $display("FAIL rr_write_bus got=%h/%h want=%h/%h", seen_wr_addr, seen_wr_data, wa[c], wd[c]);
        end
        bus.core_write_valid[c] = 1'b0;
      end
    end
    rr_model = p;
    tick();
    total++;
    if ((bus.core_read_ready | bus.core_write_ready) !== '0) begin
      bad++;
      $display("FAIL rr_release got=%b want=00", bus.core_read_ready | bus.core_write_ready);
    end
  endtask

  task automatic test_contention();
    test_rr_round(2'b11, 2'b00, '{8'h40, 8'h80}, '{8'h00, 8'h00}, '{8'h00, 8'h00});
    test_rr_round(2'b11, 2'b00, '{8'h44, 8'h88}, '{8'h00, 8'h00}, '{8'h00, 8'h00});
  endtask

  task automatic test_rw_same_core();
    test_rr_round(2'b01, 2'b01, '{8'h20, 8'h00}, '{8'h21, 8'h00}, '{8'hAB, 8'h00});
  endtask

  task automatic test_random();
    logic [AB-1:0] ra [NC];
    logic [AB-1:0] wa [NC];
    logic [DB-1:0] wd [NC];
    repeat (25) begin
      for (int k = 0; k < NC; k++) begin
        ra[k] = AB'($urandom);
        wa[k] = AB'($urandom);
        wd[k] = DB'($urandom);
      end
      rd_lat = $urandom_range(0, 3);
      wr_lat = $urandom_range(0, 3);
      test_rr_round(NC'($urandom), NC'($urandom), ra, wa, wd);
    end
    rd_lat = 0;
    wr_lat = 0;
  endtask

  task automatic test_slow_memory();
    int nvalid;
    bit stable, early, ok;
    rd_lat = 5;
    nvalid = 0;
    stable = 1'b1;
    early = 1'b0;
    ok = 1'b0;
    bus.core_read_address[0 +: AB] = 8'h30;
    bus.core_read_valid = 2'b01;
    for (int c = 0; c < 40; c++) begin
      tick();
      if ((bus.core_read_ready | bus.core_write_ready) != '0) begin ok = 1'b1; break; end
      if (bus.mem_read_valid) begin
        nvalid++;
        if (bus.mem_read_address !== 8'h30) stable = 1'b0;
      end else if (nvalid > 0) stable = 1'b0;
      if (nvalid > 0 && nvalid <= rd_lat && bus.mem_read_ready) early = 1'b1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL slow_timeout got=no-ready want=ready"); end
    total++;
    if (!stable) begin bad++; $display("FAIL slow_stable got=unstable want=held at 30"); end
    total++;
    if (nvalid != rd_lat + 1 || early) begin bad++; $display("FAIL slow_wait got=%0d want=%0d", nvalid, rd_lat + 1); end
    exp_line[0] = line_of(8'h30);
    total++;
    if (bus.core_read_ready !== 2'b01 || bus.mem_read_valid !== 1'b0 || bus.core_read_data !== flat_lines()) begin
      bad++;
      $display("FAIL slow_done got=%b/%b/%h want=01/0/%h", bus.core_read_ready, bus.mem_read_valid, bus.core_read_data, flat_lines());
    end
    bus.core_read_valid = 2'b00;
    rr_model = 1;
    rd_lat = 0;
    tick();
  endtask

  task automatic test_early_drop();
    bit ok, issued;
    wr_lat = 3;
    issued = 1'b0;
    bus.core_write_address[0 +: AB] = 8'h60;
    bus.core_write_data[0 +: DB] = 8'h5A;
    bus.core_write_valid = 2'b01;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.mem_write_valid) begin issued = 1'b1; break; end
    end
    total++;
    if (!issued) begin bad++; $display("FAIL drop_issue got=no-valid want=mem_write_valid"); end
    bus.core_write_valid = 2'b00;
    wait_ready(ok);
    total++;
    if (!ok || bus.core_write_ready !== 2'b01 || bus.core_read_ready !== 2'b00) begin
      bad++;
      $display("FAIL drop_ready got=%b/%b want=00/01", bus.core_read_ready, bus.core_write_ready);
    end
    total++;
    if (seen_wr_addr !== 8'h60 || seen_wr_data !== 8'h5A) begin
      bad++;
      $display("FAIL drop_bus got=%h/%h want=60/5a", seen_wr_addr, seen_wr_data);
    end
    tick();
    total++;
    if (bus.core_write_ready !== 2'b00 || bus.mem_write_valid !== 1'b0) begin
      bad++;
      $display("FAIL drop_pulse got=%b/%b want=00/0", bus.core_write_ready, bus.mem_write_valid);
    end
    rr_model = 1;
    wr_lat = 0;
  endtask

  task automatic test_reset_mid_read();
    bit ok, issued;
    rd_lat = 10;
    issued = 1'b0;
    bus.core_read_address[AB +: AB] = 8'h40;
    bus.core_read_valid = 2'b10;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.mem_read_valid) begin issued = 1'b1; break; end
    end
    total++;
    if (!issued) begin bad++; $display("FAIL rst_issue got=no-valid want=mem_read_valid"); end
    tick();
    reset = 1'b0;
    bus.core_read_valid = 2'b00;
    #1;
    total++;
    if ({bus.mem_read_valid, bus.mem_write_valid, bus.core_read_ready, bus.core_write_ready} !== '0 ||
        {bus.mem_read_address, bus.mem_write_address, bus.mem_write_data} !== '0 || bus.core_read_data !== '0) begin
      bad++;
      $display("FAIL rst_async got=%b/%h/%h want=0", {bus.mem_read_valid, bus.mem_write_valid, bus.core_read_ready, bus.core_write_ready},
               {bus.mem_read_address, bus.mem_write_address, bus.mem_write_data}, bus.core_read_data);
    end
    for (int k = 0; k < NC; k++) exp_line[k] = '0;
    repeat (2) tick();
    reset = 1'b1;
    rd_lat = 0;
    tick();
    bus.core_read_address[0 +: AB] = 8'h50;
    bus.core_read_valid = 2'b01;
    wait_ready(ok);
    exp_line[0] = line_of(8'h50);
    total++;
    if (!ok || bus.core_read_ready !== 2'b01 || seen_rd_addr !== 8'h50) begin
      bad++;
      $display("FAIL rst_fresh got=%b/%h want=01/50", bus.core_read_ready, seen_rd_addr);
    end
    total++;
    if (bus.core_read_data !== flat_lines()) begin
      bad++;
      $display("FAIL rst_fresh_data got=%h want=%h", bus.core_read_data, flat_lines());
    end
    bus.core_read_valid = 2'b00;
    rr_model = 1;
    tick();
  endtask

  initial begin
    bus.core_read_valid = '0;
    bus.core_read_address = '0;
    bus.core_write_valid = '0;
    bus.core_write_address = '0;
    bus.core_write_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = DB'($urandom);
    mem[8'h10] = 8'h11;
    mem[8'h11] = 8'h22;
    mem[8'h12] = 8'h33;
    mem[8'h13] = 8'h44;
    test_reset();
    test_single_read();
    test_contention();
    test_rw_same_core();
    test_random();
    test_slow_memory();
    test_early_drop();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
